// File: rtl/conv_enc_packer.sv
`default_nettype none
// ============================================================================
// Module      : conv_enc_packer
// Description : Rate-1/2 convolutional encoder with a symbol packer.
//               Each accepted DATA_W-bit word is encoded LSB first, one bit
//               per clock, and the DATA_W symbol pairs are packed into one
//               2*DATA_W-bit output word. Pair i sits at [2i+1:2i] with
//               [2i]=c0 and [2i+1]=c1. Encoder memory carries across words
//               and is cleared by reset or at frame end.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_data/in_valid/in_last/in_ready - input word handshake
//               out_data/out_valid/out_ready      - packed output handshake
// Config      : `define CONV_ENC_TAIL_EN to flush the encoder after a frame
//               with an extra all-zero-input tail word. Without it, the
//               encoder memory is simply cleared at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_enc_packer #(
    parameter int             DATA_W = 8,
    parameter int             K      = 3,
    parameter logic [K-1:0]   G0     = 3'b111,
    parameter logic [K-1:0]   G1     = 3'b101
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int                 c_CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_OUT   = 2'd2;
`ifdef CONV_ENC_TAIL_EN
    localparam logic [1:0] c_ST_TAIL  = 2'd3;
`endif

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_W-1:0]     r_word;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [K-2:0]          r_mem;
    logic [K-2:0]          w_mem_nxt;
    logic                  r_tail_pend;
    logic [2*DATA_W-1:0]   r_pack;
    logic [2*DATA_W-1:0]   w_pack_nxt;
    logic [2*DATA_W-1:0]   r_out_data;
    logic                  r_out_valid;

    logic                  w_shift_en;
    logic                  w_accept;
    logic                  w_release;
    logic                  w_last_bit;
    logic                  w_bit;
    logic [K-1:0]          w_win;
    logic                  w_c0;
    logic                  w_c1;

    // ------------------------------------------------------------------------
    // Encoder core: window holds the current bit at [0] and older bits above.
    // ------------------------------------------------------------------------
    assign w_last_bit = (r_cnt == c_CNT_LAST);
    assign w_bit      = (r_state == c_ST_SHIFT) ? r_word[r_cnt] : 1'b0;
    assign w_win      = {r_mem, w_bit};
    assign w_c0       = ^(w_win & G0);
    assign w_c1       = ^(w_win & G1);

    generate
        if (K == 2) begin : g_mem_k2
            assign w_mem_nxt = w_bit;
        end else begin : g_mem_kn
            assign w_mem_nxt = {r_mem[K-3:0], w_bit};
        end
    endgenerate

    // The final pair is merged combinationally so the complete word can load
    // into out_data on the same edge that encodes the last bit.
    always_comb begin
        w_pack_nxt = r_pack;
        w_pack_nxt[{r_cnt, 1'b0} +: 2] = {w_c1, w_c0};
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_last_bit) begin
                    w_state_nxt = c_ST_OUT;
                end
            end
            c_ST_OUT: begin
                if (out_ready) begin
`ifdef CONV_ENC_TAIL_EN
                    w_state_nxt = r_tail_pend ? c_ST_TAIL : c_ST_IDLE;
`else
                    w_state_nxt = c_ST_IDLE;
`endif
                end
            end
`ifdef CONV_ENC_TAIL_EN
            c_ST_TAIL: begin
                if (w_last_bit) begin
                    w_state_nxt = c_ST_OUT;
                end
            end
`endif
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state-decoded controls (in_ready depends on state only)
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready   = (r_state == c_ST_IDLE);
        w_accept   = (r_state == c_ST_IDLE) && in_valid;
        w_release  = (r_state == c_ST_OUT) && out_ready;
`ifdef CONV_ENC_TAIL_EN
        w_shift_en = (r_state == c_ST_SHIFT) || (r_state == c_ST_TAIL);
`else
        w_shift_en = (r_state == c_ST_SHIFT);
`endif
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_cnt       <= '0;
            r_mem       <= '0;
            r_tail_pend <= 1'b0;
            r_pack      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word      <= in_data;
                r_cnt       <= '0;
                r_tail_pend <= in_last;
            end

            if (w_shift_en) begin
                r_mem  <= w_mem_nxt;
                r_pack <= w_pack_nxt;
                if (w_last_bit) begin
                    r_cnt       <= '0;
                    r_out_data  <= w_pack_nxt;
                    r_out_valid <= 1'b1;
`ifdef CONV_ENC_TAIL_EN
                    // Tail word done: memory has been flushed by zero inputs.
                    if (r_state == c_ST_TAIL) begin
                        r_tail_pend <= 1'b0;
                    end
`endif
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            if (w_release) begin
                r_out_valid <= 1'b0;
`ifndef CONV_ENC_TAIL_EN
                // Frame end without a tail: restart the next frame from zero.
                if (r_tail_pend) begin
                    r_mem       <= '0;
                    r_tail_pend <= 1'b0;
                end
`endif
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_enc_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_enc_packer
// Description : Self-checking bench for conv_enc_packer. A default instance
//               (DATA_W=8, K=3, G0=111, G1=101) is checked against a bench
//               scoreboard; a second instance (DATA_W=4, K=2, G0=11, G1=01)
//               is checked against hand-derived words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_enc_packer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic [3:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_last;
    logic        b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;

    conv_enc_packer u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    conv_enc_packer #(
        .DATA_W (4),
        .K      (2),
        .G0     (2'b11),
        .G1     (2'b01)
    ) u_dut_k2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_last   (b_in_last),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    // Encoder history of the reference: p1 = previous bit, p2 = two back.
    logic        m_p1;
    logic        m_p2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference for generators 7/5: c0 = b^b[-1]^b[-2], c1 = b^b[-2].
    function automatic logic [15:0] model_word(input logic [7:0] d);
        logic [15:0] r;
        logic        b;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            b          = d[i];
            r[2*i]     = b ^ m_p1 ^ m_p2;
            r[2*i+1]   = b ^ m_p2;
            m_p2       = m_p1;
            m_p1       = b;
        end
        return r;
    endfunction

    task automatic do_reset;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_last   = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        exp_q.delete();
        m_p1 = 1'b0;
        m_p2 = 1'b0;
    endtask

    // Offer one word; expected output word(s) go onto the scoreboard.
    task automatic send_word(input logic [7:0] d, input logic last);
        int budget;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            tick;
            budget++;
        end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL send_wait: in_ready=%b required 1", in_ready);
        else n_pass++;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        exp_q.push_back(model_word(d));
`ifdef CONV_ENC_TAIL_EN
        if (last) exp_q.push_back(model_word(8'h00));
`else
        if (last) begin
            m_p1 = 1'b0;
            m_p2 = 1'b0;
        end
`endif
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for an output word, take it with a one-cycle out_ready.
    task automatic recv_word(output logic [15:0] got, output bit ok);
        int budget;
        budget = 0;
        while (out_valid !== 1'b1 && budget < 40) begin
            tick;
            budget++;
        end
        ok  = (out_valid === 1'b1);
        got = out_data;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    function automatic logic [15:0] pop_exp();
        if (exp_q.size() == 0) return 16'hxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset;
        do_reset;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h required 0000", out_data);
        else n_pass++;
    endtask

    task automatic test_latency;
        int          lat;
        bit          busy_ok;
        logic [15:0] got;
        logic [15:0] exp;
        do_reset;
        send_word(8'h01, 1'b0);
        lat     = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 30) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            tick;
            lat++;
        end
        n_checks++;
        if (lat != 8) $display("FAIL latency: got %0d cycles required 8", lat);
        else n_pass++;
        n_checks++;
        if (!busy_ok || in_ready !== 1'b0) $display("FAIL busy_in_ready: got %b required 0", in_ready);
        else n_pass++;
        got = out_data;
        exp = pop_exp();
        n_checks++;
        if (got !== exp || got !== 16'h0037) $display("FAIL word_01: got %h required %h", got, exp);
        else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL handshake: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_carry;
        logic [15:0] got;
        logic [15:0] exp;
        bit          ok;
        do_reset;
        send_word(8'hFF, 1'b0);
        recv_word(got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok || got !== exp || got !== 16'h555B) $display("FAIL carry_ff: got %h required %h", got, exp);
        else n_pass++;
        send_word(8'h00, 1'b0);
        recv_word(got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok || got !== exp || got !== 16'h000E) $display("FAIL carry_00: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_frame_end;
        logic [15:0] got;
        logic [15:0] exp;
        bit          ok;
        do_reset;
        send_word(8'hFF, 1'b1);
        recv_word(got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok || got !== exp || got !== 16'h555B) $display("FAIL frame_ff: got %h required %h", got, exp);
        else n_pass++;
`ifdef CONV_ENC_TAIL_EN
        recv_word(got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok || got !== exp || got !== 16'h000E) $display("FAIL tail_word: got %h required %h", got, exp);
        else n_pass++;
`else
        begin
            bit quiet;
            quiet = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
                tick;
            end
            n_checks++;
            if (!quiet) $display("FAIL no_tail: got an extra word or busy, required idle");
            else n_pass++;
        end
`endif
        send_word(8'h01, 1'b0);
        recv_word(got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok || got !== exp || got !== 16'h0037) $display("FAIL after_frame: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [15:0] hold;
        logic [15:0] exp;
        int          budget;
        bit          quiet;
        do_reset;
        send_word(8'h5A, 1'b0);
        budget = 0;
        while (out_valid !== 1'b1 && budget < 40) begin
            tick;
            budget++;
        end
        hold = out_data;
        exp  = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || hold !== exp) $display("FAIL bp_word: got %h required %h", hold, exp);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'h33;
            in_valid = 1'b1;
            tick;
            n_checks++;
            if (out_data !== hold || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got data=%h valid=%b in_ready=%b required %h/1/0",
                         i, out_data, out_valid, in_ready, hold);
            else n_pass++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else n_pass++;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) quiet = 1'b0;
            tick;
        end
        n_checks++;
        if (!quiet) $display("FAIL bp_ignored: got out_valid=1 required 0");
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [15:0] got;
        logic [15:0] exp;
        bit          ok;
        do_reset;
        send_word(8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete();
        m_p1 = 1'b0;
        m_p2 = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else n_pass++;
        send_word(8'h01, 1'b0);
        recv_word(got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok || got !== exp || got !== 16'h0037) $display("FAIL mid_reset_word: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] got;
        logic [15:0] exp;
        bit          ok;
        logic [7:0]  d;
        do_reset;
        for (int w = 0; w < 6; w++) begin
            d = 8'($urandom_range(0, 255));
            send_word(d, (w == 2));
            while (exp_q.size() != 0) begin
                recv_word(got, ok);
                exp = pop_exp();
                n_checks++;
                if (!ok || got !== exp) $display("FAIL b2b_%0d: in %h got %h required %h", w, d, got, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_params;
        int budget;
        do_reset;
        n_checks++;
        if (b_in_ready !== 1'b1) $display("FAIL k2_reset: got in_ready=%b required 1", b_in_ready);
        else n_pass++;
        b_in_data  = 4'h1;
        b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        budget = 0;
        while (b_out_valid !== 1'b1 && budget < 20) begin
            tick;
            budget++;
        end
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'h07) $display("FAIL k2_word1: got %h required 07", b_out_data);
        else n_pass++;
        b_out_ready = 1'b1;
        tick;
        b_out_ready = 1'b0;
        b_in_data   = 4'hB;
        b_in_valid  = 1'b1;
        tick;
        b_in_valid  = 1'b0;
        budget = 0;
        while (b_out_valid !== 1'b1 && budget < 20) begin
            tick;
            budget++;
        end
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hDB) $display("FAIL k2_word2: got %h required DB", b_out_data);
        else n_pass++;
        b_out_ready = 1'b1;
        tick;
        b_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset;
        test_latency;
        test_carry;
        test_frame_end;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_params;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/conv_enc_packer.md
Name: conv_enc_packer

Overview:
- Parametrised successor to the fixed rate-1/2 serial encoder plus 8-pair symbol packer.
- Accepts DATA_W-bit words over a valid/ready handshake and encodes them LSB first, one bit per clock, with a rate-1/2 convolutional code of generic constraint length and generators.
- Packs DATA_W symbol pairs into one 2*DATA_W-bit output word with valid/ready back-pressure.
- Drives the data_rcv word of the pipelined Viterbi decoder in the single-clock bench and in system use.

Parameters:
- DATA_W, 8: information bits per input word; output word is 2*DATA_W bits.
- K, 3: constraint length, 2..DATA_W+1.
- G0, 3'b111: generator 0, K bits; bit j taps the input j steps earlier, bit 0 = current bit.
- G1, 3'b101: generator 1, same format.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  information word; bit 0 is encoded first.
- in_valid  in  1  in_data is valid.
- in_last  in  1  word ends a frame; sampled with in_data.
- in_ready  out  1  block can accept a word.
- out_data  out  2*DATA_W  packed symbols; pair i is at [2i+1:2i], with [2i]=c0 and [2i+1]=c1.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data.

Behaviour:
- Reset (rst=1 at an edge), applied in any state, mid-word included:
  - state=IDLE, encoder memory s[K-2:0]=0, bit counter=0, tail pending flag=0.
  - out_valid=0, out_data=0, in_ready=1 after that edge.
- Encoder: window w = {s, b} with w[0]=b (current bit) and w[j]=s[j-1].
  - c0 = ^(w & G0), c1 = ^(w & G1).
  - Each encoded bit: s <= {s[K-3:0], b}; for K=2, s <= b.
- Memory persists across words; it is cleared only by reset or frame end (see Optional Feature).
- States:
  - IDLE: in_ready=1. in_valid=1 captures in_data and in_last, counter=0, go to SHIFT.
  - SHIFT: in_ready=0. One bit per cycle, bit index = counter. The pair is written to a packing register at [2*cnt+1:2*cnt].
    - On the edge encoding bit DATA_W-1, the full word (including the last pair) loads into out_data, out_valid=1, go to OUT.
  - OUT: out_data held stable while out_valid=1 and out_ready=0.
    - On out_ready=1: out_valid=0, go to TAIL if a tail is pending, else IDLE.
  - TAIL: only exists with the optional feature; behaves as SHIFT with b=0 for all DATA_W bits, then OUT with the tail flag cleared.
- Latency: word accepted at edge E0 → out_valid=1 after edge E0+DATA_W. Minimum word period is DATA_W+2 cycles.
- No new word is accepted while in SHIFT, OUT or TAIL; in_valid is ignored there.
- out_valid=1 with out_ready=1 in the same cycle the word loads is impossible, because the load and OUT entry coincide.
- Counter width is clog2(DATA_W); the counter wraps to 0 at the end of every word.
- All outputs are registered; no combinational path from inputs to outputs except none (in_ready is derived from state only).

Optional Feature:
- Macro: CONV_ENC_TAIL_EN.
- Defined:
  - A word accepted with in_last=1 sets the tail-pending flag.
  - After that word's OUT handshake, the block enters TAIL and emits one extra output word: DATA_W zero inputs encoded from the current memory.
  - This leaves s=0 (K-1 ≤ DATA_W guaranteed by parameter range); then IDLE.
- Undefined:
  - No TAIL state and no extra word.
  - in_last=1 clears s to 0 on the handshake edge that completes that word's OUT; the next word starts from the zero state.

Test Plan:
1. Defaults, after reset, in_data=8'h01 in_last=0 → out_data=16'h0037, out_valid rising 8 cycles after acceptance, in_ready=0 until handshake.
2. 8'hFF then 8'h00, in_last=0, from reset → outputs 16'h555B then 16'h000E (memory carried across words).
3. CONV_ENC_TAIL_EN, 8'hFF with in_last=1 → 16'h555B then tail word 16'h000E; next 8'h01 → 16'h0037. Without macro: 16'h555B, then 8'h01 → 16'h0037, no extra word.
4. Back-pressure: hold out_ready=0 for 5 cycles with out_valid=1 → out_data stable, in_ready=0, in_valid pulses ignored; word released on the first out_ready=1 edge.
5. Reset mid-word: assert rst at counter=4 of 8'hFF → next cycle out_valid=0, in_ready=1, s=0; following 8'h01 → 16'h0037.
6. Non-default parameters: DATA_W=4, K=2, G0=2'b11, G1=2'b01, 4'h1 → pairs 11, 01, 00, 00 → out_data=8'h07.
